// File: rtl/opsum_reducer.sv
// Output-psum reducer: per-row add of PE partial sums and buffered input psums, streamed two rows per word.
// Optional signed saturation and sticky sat_flag output are enabled by defining REDUCER_SAT_EN.

module opsum_reducer #(
    parameter int ROW_NUM = 32,
    parameter int DW      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [5:0]            row_en,
    input  logic [ROW_NUM*DW-1:0] ipsum_in,
    input  logic [ROW_NUM*DW-1:0] pe_psum,
    input  logic                  pe_valid,
    output logic                  pe_ready,
    output logic                  ipsum_out_f,
    output logic [2*DW-1:0]       opsum_out,
    output logic                  valid_op,
    input  logic                  ready_op,
    output logic                  busy,
    output logic                  done
`ifdef REDUCER_SAT_EN
    ,
    output logic                  sat_flag
`endif
);

    localparam int IW = $clog2(ROW_NUM);
    localparam int RW = 6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_DONE
    } state_t;

    state_t          state, next_state;
    logic [IW-2:0]   word_cnt;
    logic [RW-1:0]   rows_q;
    logic [RW-1:0]   rows_in;
    logic [DW-1:0]   sum_bank [ROW_NUM];
    logic [DW-1:0]   lane_val [ROW_NUM];
    logic            accept;
    logic            last_word;

`ifdef REDUCER_SAT_EN
    logic            any_sat;

    // Returns {saturated, result}; overflow shows as disagreement of the two top bits.
    function automatic logic [DW:0] sat_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW:0] ext;
        ext = {a[DW-1], a} + {b[DW-1], b};
        if (ext[DW] != ext[DW-1])
            return {1'b1, ext[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}}};
        return {1'b0, ext[DW-1:0]};
    endfunction
`endif

    assign rows_in   = (row_en > RW'(ROW_NUM)) ? RW'(ROW_NUM) : row_en;
    // Word k carries rows 2k and 2k+1; it is the last once row 2k+1 reaches the active count.
    assign last_word = (RW'({word_cnt, 1'b1}) + RW'(1)) >= rows_q;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
`ifdef REDUCER_SAT_EN
        logic sat_bit;
        sat_bit = 1'b0;
        any_sat = 1'b0;
`endif
        for (int r = 0; r < ROW_NUM; r++) begin
            lane_val[r] = '0;
            if (RW'(r) < rows_in) begin
`ifdef REDUCER_SAT_EN
                {sat_bit, lane_val[r]} = sat_add(pe_psum[r*DW +: DW], ipsum_in[r*DW +: DW]);
                any_sat = any_sat | sat_bit;
`else
                lane_val[r] = pe_psum[r*DW +: DW] + ipsum_in[r*DW +: DW];
`endif
            end
        end
    end

    always_comb begin
        next_state  = state;
        pe_ready    = 1'b0;
        accept      = 1'b0;
        ipsum_out_f = 1'b0;
        valid_op    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        opsum_out   = '0;
        case (state)
            S_IDLE: begin
                pe_ready = 1'b1;
                if (pe_valid) begin
                    accept      = 1'b1;
                    ipsum_out_f = (row_en != '0);
                    next_state  = (row_en == '0) ? S_DONE : S_SEND;
                end
            end
            S_SEND: begin
                busy      = 1'b1;
                valid_op  = 1'b1;
                opsum_out = {sum_bank[{word_cnt, 1'b0}], sum_bank[{word_cnt, 1'b1}]};
                if (ready_op && last_word)
                    next_state = S_DONE;
            end
            S_DONE: begin
                done       = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            word_cnt <= '0;
            rows_q   <= '0;
`ifdef REDUCER_SAT_EN
            sat_flag <= 1'b0;
`endif
        end else begin
            state <= next_state;
            if (accept) begin
                rows_q   <= rows_in;
                word_cnt <= '0;
`ifdef REDUCER_SAT_EN
                sat_flag <= any_sat;
`endif
            end else if (valid_op && ready_op) begin
                word_cnt <= word_cnt + 1'b1;
            end
        end
    end

    // NOTE: the sum bank is reset explicitly because its contents drive opsum_out and must be known after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < ROW_NUM; r++)
                sum_bank[r] <= '0;
        end else if (accept && row_en != '0) begin
            for (int r = 0; r < ROW_NUM; r++)
                sum_bank[r] <= lane_val[r];
        end
    end

endmodule

// File: tb/tb_opsum_reducer.sv
// Scoreboard bench for opsum_reducer: random and directed psum sets against a per-row arithmetic reference.
// Define REDUCER_SAT_EN for both files to exercise the saturating build.

module tb_opsum_reducer;

    localparam int ROW_NUM = 32;
    localparam int DW      = 16;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [5:0]            row_en;
    logic [ROW_NUM*DW-1:0] ipsum_in;
    logic [ROW_NUM*DW-1:0] pe_psum;
    logic                  pe_valid;
    logic                  pe_ready;
    logic                  ipsum_out_f;
    logic [31:0]           opsum_out;
    logic                  valid_op;
    logic                  ready_op;
    logic                  busy;
    logic                  done;
`ifdef REDUCER_SAT_EN
    logic                  sat_flag;
`endif

    opsum_reducer #(.ROW_NUM(ROW_NUM), .DW(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .row_en     (row_en),
        .ipsum_in   (ipsum_in),
        .pe_psum    (pe_psum),
        .pe_valid   (pe_valid),
        .pe_ready   (pe_ready),
        .ipsum_out_f(ipsum_out_f),
        .opsum_out  (opsum_out),
        .valid_op   (valid_op),
        .ready_op   (ready_op),
        .busy       (busy),
        .done       (done)
`ifdef REDUCER_SAT_EN
        ,
        .sat_flag   (sat_flag)
`endif
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          hs_cnt = 0;
    int          f_cnt  = 0;
    int          rdy_mode = 0;
    bit          exp_sat;
    logic [31:0] exp_q [$];
    logic [15:0] pe_l [ROW_NUM];
    logic [15:0] ip_l [ROW_NUM];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference lane add on plain integers.
    function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b, output bit sat);
        int s;
        s   = int'($signed(a)) + int'($signed(b));
        sat = 1'b0;
`ifdef REDUCER_SAT_EN
        if (s > 32767)  begin sat = 1'b1; return 16'h7FFF; end
        if (s < -32768) begin sat = 1'b1; return 16'h8000; end
`endif
        return 16'(s);
    endfunction

    task automatic model_push(input int n_en);
        int          n;
        bit          sat;
        logic [15:0] s [ROW_NUM];
        n       = (n_en > ROW_NUM) ? ROW_NUM : n_en;
        exp_sat = 1'b0;
        for (int i = 0; i < n; i++) begin
            s[i] = ref_add(pe_l[i], ip_l[i], sat);
            if (sat) exp_sat = 1'b1;
        end
        for (int k = 0; 2*k < n; k++)
            exp_q.push_back({s[2*k], (2*k+1 < n) ? s[2*k+1] : 16'h0000});
    endtask

    task automatic fill_random();
        for (int i = 0; i < ROW_NUM; i++) begin
            pe_l[i] = 16'($urandom);
            ip_l[i] = 16'($urandom);
        end
    endtask

    task automatic drive_lanes();
        for (int i = 0; i < ROW_NUM; i++) begin
            pe_psum[i*DW +: DW]  = pe_l[i];
            ipsum_in[i*DW +: DW] = ip_l[i];
        end
    endtask

    // Issues one psum set, then waits (bounded) for done and checks the set's bookkeeping.
    task automatic send_set(input int n_en, input bit hold);
        int n, w, c, f0, h0;
        n = (n_en > ROW_NUM) ? ROW_NUM : n_en;
        w = (n + 1) / 2;
        c = 0;
        while (!pe_ready && c < 100) begin
            @(posedge clk); #1; c++;
        end
        check("ready_before_set", pe_ready, 1);
        drive_lanes();
        row_en   = 6'(n_en);
        pe_valid = 1'b1;
        model_push(n_en);
        f0 = f_cnt;
        h0 = hs_cnt;
        @(posedge clk); #1;
        if (!hold) pe_valid = 1'b0;
        if (rdy_mode == 0 && n > 0) check("first_word_latency", valid_op, 1);
        c = 0;
        while (!done && c < 200) begin
            if (hold)
                for (int i = 0; i < ROW_NUM; i++) pe_psum[i*DW +: DW] = 16'($urandom);
            @(posedge clk); #1; c++;
        end
        pe_valid = 1'b0;
        check("done_seen", done, 1);
        if (rdy_mode == 0) check("done_latency", c, w);
        check("done_valid_low", valid_op, 0);
        check("done_ready_low", pe_ready, 0);
        check("words_left", exp_q.size(), 0);
        check("handshakes", hs_cnt - h0, w);
        check("shift_pulses", f_cnt - f0, (n > 0) ? 1 : 0);
`ifdef REDUCER_SAT_EN
        check("sat_flag", sat_flag, exp_sat);
`endif
        @(posedge clk); #1;
        check("ready_after_done", pe_ready, 1);
        check("done_one_cycle", done, 0);
    endtask

    // Ready driver: always high, alternating, or random.
    initial begin
        ready_op = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       ready_op = 1'b1;
                1:       ready_op = ~ready_op;
                default: ready_op = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops the scoreboard on every handshake and checks word hold under backpressure.
    initial begin
        logic        pv = 1'b0;
        logic        pr = 1'b0;
        logic [31:0] pw = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (pv && !pr) begin
                    check("hold_valid", valid_op, 1);
                    check("hold_data", opsum_out, pw);
                end
                if (busy) check("ready_in_send", pe_ready, 0);
                if (ipsum_out_f) begin
                    f_cnt++;
                    check("shift_when_ready", pe_ready, 1);
                end
                if (valid_op && ready_op) begin
                    hs_cnt++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word: got %h expected no word", opsum_out);
                    end else begin
                        check("word", opsum_out, exp_q.pop_front());
                    end
                end
                pv = valid_op;
                pr = ready_op;
                pw = opsum_out;
            end else begin
                pv = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c, h0, h1;
        reset    = 1'b0;
        pe_valid = 1'b0;
        row_en   = '0;
        pe_psum  = '0;
        ipsum_in = '0;
        #3;
        check("rst_pe_ready", pe_ready, 1);
        check("rst_valid_op", valid_op, 0);
        check("rst_opsum", opsum_out, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_shift", ipsum_out_f, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_pe_ready", pe_ready, 1);
        check("idle_valid_op", valid_op, 0);
        check("idle_busy", busy, 0);

        // Four rows, small values, ready held high.
        rdy_mode = 0;
        fill_random();
        for (int i = 0; i < 4; i++) begin
            pe_l[i] = 16'(i + 1);
            ip_l[i] = 16'(10 * (i + 1));
        end
        send_set(4, 1'b0);

        // Three rows with alternating ready.
        rdy_mode = 1;
        for (int i = 0; i < ROW_NUM; i++) begin
            pe_l[i] = 16'd5;
            ip_l[i] = 16'd5;
        end
        send_set(3, 1'b0);

        // Positive overflow on every lane.
        rdy_mode = 0;
        for (int i = 0; i < ROW_NUM; i++) begin
            pe_l[i] = 16'h7FFF;
            ip_l[i] = 16'h0001;
        end
        send_set(32, 1'b0);

        // Negative overflow on five lanes.
        for (int i = 0; i < ROW_NUM; i++) begin
            pe_l[i] = 16'h8000;
            ip_l[i] = 16'hFFFF;
        end
        send_set(5, 1'b0);

        // pe_valid held through SEND with changing pe_psum, then a back-to-back set.
        rdy_mode = 2;
        fill_random();
        send_set(10, 1'b1);
        fill_random();
        send_set(7, 1'b0);

        // Reset in the middle of an eight-word set.
        rdy_mode = 0;
        fill_random();
        drive_lanes();
        row_en   = 6'd16;
        pe_valid = 1'b1;
        model_push(16);
        h0 = hs_cnt;
        @(posedge clk); #1;
        pe_valid = 1'b0;
        c = 0;
        while (hs_cnt < h0 + 2 && c < 50) begin
            @(posedge clk); #1; c++;
        end
        check("mid_words_before_reset", hs_cnt - h0, 2);
        reset = 1'b0;
        #1;
        check("mid_rst_valid_op", valid_op, 0);
        check("mid_rst_opsum", opsum_out, 0);
        check("mid_rst_busy", busy, 0);
        exp_q.delete();
        h1 = hs_cnt;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("post_rst_pe_ready", pe_ready, 1);
        check("post_rst_valid_op", valid_op, 0);
        check("post_rst_no_words", hs_cnt - h1, 0);

        // Zero rows: straight to done.
        fill_random();
        send_set(0, 1'b0);

        // Random sets, including row counts above 32.
        for (int t = 0; t < 25; t++) begin
            rdy_mode = $urandom_range(0, 2);
            fill_random();
            send_set($urandom_range(1, 63), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/opsum_reducer.md
Name: opsum_reducer

Overview:
- Sits directly downstream of the input-psum buffer and the PE array.
- Per active row, adds the PE-array partial sum to the oldest buffered input psum (one 16-bit lane each) and holds the results in a sum bank.
- Packs the sum bank two rows per 32-bit word and streams the words to the GLB over a valid/ready handshake.
- Pulses the buffer's shift request so the buffer presents its next entry.

Parameters:
- ROW_NUM, 32, number of PE rows / 16-bit lanes.
- DW, 16, psum lane width in bits.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset
- row_en  input  6  number of active rows, 1..32; sampled on accept
- ipsum_in  input  ROW_NUM*DW  oldest entry per row from input-psum buffer; lane r = bits [r*16 +: 16]
- pe_psum  input  ROW_NUM*DW  PE-array partial sums; same lane layout
- pe_valid  input  1  pe_psum valid
- pe_ready  output  1  reducer can accept a new psum set
- ipsum_out_f  output  1  shift request to input-psum buffer
- opsum_out  output  32  packed result word to GLB
- valid_op  output  1  opsum_out valid
- ready_op  input  1  GLB accepts word
- busy  output  1  SEND state active
- done  output  1  one-cycle pulse after last word accepted

Behaviour:
- Reset (reset=0, asynchronous):
  - State becomes IDLE; word counter, sum bank and latched row count cleared.
  - Outputs at reset: pe_ready=1, valid_op=0, opsum_out=0, busy=0, done=0, ipsum_out_f=0.
- States:
  - IDLE:
    - pe_ready=1.
    - accept = pe_valid && pe_ready.
    - On accept at cycle T:
      - sum[r] <= pe_psum lane r + ipsum_in lane r for r < rows; lanes r >= rows <= 0.
      - rows <= row_en, clamped to 32 if row_en > 32.
      - Word counter <= 0.
      - Next state SEND.
    - ipsum_out_f = accept (combinational, high in cycle T only). The buffer shifts on the same edge that samples ipsum_in.
    - row_en == 0 on accept: no sums, no words, no ipsum_out_f; go straight to DONE.
  - SEND:
    - busy=1, pe_ready=0, valid_op=1.
    - opsum_out = {sum[2k], sum[2k+1]}, where k = word counter; upper half is the even row.
    - Odd rows count: the last word's lower half = 16'h0000.
    - Word count = ceil(rows/2); 1..16 words.
    - On valid_op && ready_op: k increments. After the last word, next state DONE.
    - opsum_out and valid_op hold stable while ready_op=0.
    - pe_valid is ignored; pe_ready=0 provides backpressure.
  - DONE:
    - done=1 for exactly one cycle.
    - pe_ready=0 and valid_op=0 in this cycle.
    - Next state IDLE.
- Latency: accept at T → first valid_op at T+1. With ready_op held high, the last word is accepted at T+ceil(rows/2), done is high in the following cycle, and pe_ready=1 again one cycle after that.
- Arithmetic: 16-bit two's-complement add, wrap-around modulo 2^16 (default build).
- No re-accept during SEND or DONE: minimum 2-cycle gap between result sets beyond the word count.
- Reset asserted mid-SEND: output words are dropped, valid_op falls immediately (asynchronously), state returns to IDLE.

Optional Feature:
- Macro: REDUCER_SAT_EN.
- When defined: each lane add saturates signed: results above 32767 → 16'h7FFF, below -32768 → 16'h8000. Adds 1-bit output sat_flag, which is sticky and set when any lane saturated in the current set. sat_flag clears on the next accept and on reset.
- When undefined: wrap-around add, and no sat_flag port.

Test Plan:
- Reset then idle → pe_ready=1, valid_op=0, opsum_out=0, done=0; release reset with pe_valid=0 → state stays IDLE.
- row_en=4, pe lanes 0..3 = 1,2,3,4, ipsum lanes = 10,20,30,40, ready_op=1 → ipsum_out_f high one cycle; words 32'h000B0016 then 32'h0021002C on consecutive cycles; done pulses the cycle after.
- row_en=3, all lanes pe=5, ipsum=5, ready_op toggled 0/1 → words 32'h000A000A then 32'h000A0000; each word is held while ready_op=0; exactly 2 handshakes occur.
- row_en=32, pe=16'h7FFF, ipsum=16'h0001 → 16 words of 32'h80008000 (default build); with REDUCER_SAT_EN → 16 words of 32'h7FFF7FFF and sat_flag=1.
- pe_valid held high during SEND → pe_ready=0 and sum bank unchanged; a second accept occurs only after done, with ipsum_out_f pulsed once per accept.
- Reset low after word 2 of 8 → valid_op=0 immediately; after release, state is IDLE with pe_ready=1 and no further words; row_en=0 accept → done next cycle, no valid_op, no ipsum_out_f.
